// File: rtl/seg_display_driver.sv
// seg_display_driver
// Converts a 12-bit binary value to four BCD digits with a sequential
// double-dabble engine (one shift per clock) and scans the result onto a
// 4-digit multiplexed common-anode 7-segment display with leading-zero
// blanking and a fixed decimal point.
module seg_display_driver #(
   parameter int REFRESH_DIV = 100000,
   parameter bit DP_EN       = 1'b1,
   parameter int DP_DIGIT    = 2,
   parameter bit LZ_BLANK    = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] value,
   input  logic        blank,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [15:0] bcd,
   output logic        busy
);

   localparam int              CNT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [1:0]       DP_IDX   = 2'(DP_DIGIT);

   typedef enum logic {IDLE, SHIFT} state_t;

   // Double-dabble correction: add 3 to every nibble that is 5 or more so
   // the following left shift carries correctly into the next decade.
   function automatic logic [15:0] dabble_adj(input logic [15:0] s);
      logic [15:0] r;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = (s[i*4 +: 4] >= 4'd5) ? s[i*4 +: 4] + 4'd3 : s[i*4 +: 4];
      end
      return r;
   endfunction

   // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit.
   function automatic logic [6:0] seg_encode(input logic [3:0] d);
      logic [6:0] r;
      case (d)
         4'd0:    r = 7'b1000000;
         4'd1:    r = 7'b1111001;
         4'd2:    r = 7'b0100100;
         4'd3:    r = 7'b0110000;
         4'd4:    r = 7'b0011001;
         4'd5:    r = 7'b0010010;
         4'd6:    r = 7'b0000010;
         4'd7:    r = 7'b1111000;
         4'd8:    r = 7'b0000000;
         4'd9:    r = 7'b0010000;
         default: r = 7'b1111111;
      endcase
      return r;
   endfunction

   // Control state
   state_t            state_q, state_d;
   logic              busy_q, busy_d;
   logic              pend_q, pend_d;
   logic [3:0]        count_q, count_d;
   logic [15:0]       bcd_q, bcd_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        idx_q, idx_d;
   logic [3:0]        an_q, an_d;
   logic [6:0]        seg_q, seg_d;
   logic              dp_q, dp_d;

   // Conversion datapath
   logic [11:0]       shift_q;
   logic [15:0]       scratch_q;
   logic [11:0]       last_value_q;
   logic [27:0]       step;
   logic              load, do_shift;

   // One double-dabble step: correct the scratch nibbles, then shift the
   // whole {scratch, shift register} pair left by one.
   always_comb begin
      step = {dabble_adj(scratch_q), shift_q} << 1;
   end

   // Conversion FSM: next state, busy flag and result write-back.
   always_comb begin
      state_d  = state_q;
      busy_d   = busy_q;
      pend_d   = pend_q;
      count_d  = count_q;
      bcd_d    = bcd_q;
      load     = 1'b0;
      do_shift = 1'b0;
      case (state_q)
         IDLE: begin
            if (pend_q || (value != last_value_q)) begin
               load    = 1'b1;
               pend_d  = 1'b0;
               busy_d  = 1'b1;
               count_d = 4'd0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            do_shift = 1'b1;
            count_d  = count_q + 4'd1;
            // The 12th shift result goes straight to the visible register.
            if (count_q == 4'd11) begin
               bcd_d   = step[27:12];
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Conversion control registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         pend_q  <= 1'b1;
         count_q <= 4'd0;
         bcd_q   <= 16'h0000;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         pend_q  <= pend_d;
         count_q <= count_d;
         bcd_q   <= bcd_d;
      end
   end

   // Shift/scratch registers; only meaningful while the FSM qualifies them.
   always_ff @(posedge clk) begin
      if (load) begin
         shift_q      <= value;
         scratch_q    <= 16'h0000;
         last_value_q <= value;
      end else if (do_shift) begin
         {scratch_q, shift_q} <= step;
      end
   end

   // Refresh counter and digit index: advance one digit per REFRESH_DIV clocks.
   always_comb begin
      cnt_d = cnt_q + CNT_ONE;
      idx_d = idx_q;
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         idx_d = idx_q + 2'd1;
      end
   end

   // Digit outputs for the current index, including leading-zero blanking.
   always_comb begin
      logic [3:0] lz_mask;
      logic       digit_blank;
      logic [3:0] nib;
      lz_mask = 4'b0000;
      for (int k = 1; k < 4; k++) begin
         lz_mask[k] = LZ_BLANK && !(DP_EN && (k <= DP_DIGIT)) &&
                      ((bcd_q >> (4 * k)) == 16'h0000);
      end
      digit_blank = lz_mask[idx_q];
      nib         = bcd_q[{idx_q, 2'b00} +: 4];
      an_d        = (blank || digit_blank) ? 4'b1111 : ~(4'b0001 << idx_q);
      seg_d       = digit_blank ? 7'b1111111 : seg_encode(nib);
      dp_d        = !(DP_EN && (idx_q == DP_IDX) && !digit_blank);
   end

   // Scan registers: display outputs lag the index by one clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         idx_q <= 2'd0;
         an_q  <= 4'b1111;
         seg_q <= 7'b1111111;
         dp_q  <= 1'b1;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign an   = an_q;
   assign seg  = seg_q;
   assign dp   = dp_q;
   assign bcd  = bcd_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// Testbench for seg_display_driver: directed vector table, hand-written
// corner sequences and randomized values against an arithmetic model.
`timescale 1ns/1ps
module tb_seg_display_driver;

   localparam int RDIV = 4;
   localparam bit M_DPE = 1'b1;
   localparam int M_DPD = 2;
   localparam bit M_LZ  = 1'b1;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic [11:0] value = 12'd0;
   logic        blank = 1'b0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic [15:0] bcd;
   logic        busy;

   int checks   = 0;
   int failures = 0;
   int n_edges  = 0;
   int model_cur = -1;

   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

   typedef struct {
      int          v;
      logic [15:0] exp;
   } vec_t;

   seg_display_driver #(
      .REFRESH_DIV(RDIV),
      .DP_EN(M_DPE),
      .DP_DIGIT(M_DPD),
      .LZ_BLANK(M_LZ)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .value(value),
      .blank(blank),
      .an(an),
      .seg(seg),
      .dp(dp),
      .bcd(bcd),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // clock edges seen since reset release
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) n_edges <= 0;
      else        n_edges <= n_edges + 1;
   end

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      r[15:12] = 4'(v / 1000);
      r[11:8]  = 4'((v / 100) % 10);
      r[7:4]   = 4'((v / 10) % 10);
      r[3:0]   = 4'(v % 10);
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " an"},   32'(an),   32'hF);
      check({tag, " seg"},  32'(seg),  32'h7F);
      check({tag, " dp"},   32'(dp),   32'h1);
      check({tag, " bcd"},  32'(bcd),  32'h0);
      check({tag, " busy"}, 32'(busy), 32'h0);
   endtask

   // Wait for a conversion to start and finish; check its length and result.
   task automatic wait_conv(input logic [15:0] exp, input string tag);
      int t;
      int bc;
      @(negedge clk);
      t = 0;
      while (!busy && t < 4) begin
         @(negedge clk);
         t++;
      end
      check({tag, " busy_rise"}, 32'(busy), 32'h1);
      bc = 0;
      while (busy && bc < 20) begin
         bc++;
         @(negedge clk);
      end
      check({tag, " busy_len"}, 32'(bc), 32'd12);
      check({tag, " bcd"}, 32'(bcd), 32'(exp));
   endtask

   task automatic do_convert(input int v, input logic [15:0] exp);
      value = 12'(v);
      if (v == model_cur) begin
         repeat (2) @(negedge clk);
         check($sformatf("same v=%0d bcd", v), 32'(bcd), 32'(exp));
         check($sformatf("same v=%0d busy", v), 32'(busy), 32'h0);
      end else begin
         wait_conv(exp, $sformatf("conv v=%0d", v));
      end
      model_cur = v;
   endtask

   // Check the scanned display cycle by cycle against the digits of v.
   task automatic scan_check(input int cycles, input int v);
      int d[4];
      int k;
      bit allz;
      bit bl;
      logic [3:0] ea;
      logic [6:0] es;
      logic       ed;
      d[0] = v % 10;
      d[1] = (v / 10) % 10;
      d[2] = (v / 100) % 10;
      d[3] = v / 1000;
      @(posedge clk);
      repeat (cycles) begin
         @(negedge clk);
         k = ((n_edges - 1) / RDIV) % 4;
         allz = 1'b1;
         for (int j = k; j < 4; j++) if (d[j] != 0) allz = 1'b0;
         bl = M_LZ && (k != 0) && !(M_DPE && (k <= M_DPD)) && allz;
         ea = (blank || bl) ? 4'b1111 : ~(4'b0001 << k);
         es = bl ? 7'b1111111 : seg_tab[d[k]];
         ed = (M_DPE && (k == M_DPD) && !bl) ? 1'b0 : 1'b1;
         check($sformatf("scan v=%0d k=%0d blank=%0d {an,seg,dp}", v, k, blank),
               32'({an, seg, dp}), 32'({ea, es, ed}));
      end
   endtask

   initial begin
      vec_t tbl[8];
      int v;
      tbl[0] = '{135,  16'h0135};
      tbl[1] = '{4095, 16'h4095};
      tbl[2] = '{9,    16'h0009};
      tbl[3] = '{10,   16'h0010};
      tbl[4] = '{100,  16'h0100};
      tbl[5] = '{999,  16'h0999};
      tbl[6] = '{1000, 16'h1000};
      tbl[7] = '{7,    16'h0007};

      // reset with value 0, then pending conversion after release
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      check_reset_outputs("reset held");
      rst_n = 1'b1;
      wait_conv(16'h0000, "post-reset v=0");
      model_cur = 0;
      scan_check(16, 0);

      // directed vector table
      for (int i = 0; i < 8; i++) begin
         do_convert(tbl[i].v, tbl[i].exp);
         scan_check(16, tbl[i].v);
      end

      // value change 3 cycles into a conversion is picked up afterwards
      value = 12'd50;
      @(negedge clk);
      check("mid-change busy", 32'(busy), 32'h1);
      repeat (3) @(negedge clk);
      value = 12'd75;
      begin
         int bc;
         bc = 0;
         while (busy && bc < 20) begin
            bc++;
            @(negedge clk);
         end
         check("mid-change first busy_fall", 32'(busy), 32'h0);
      end
      check("mid-change first bcd", 32'(bcd), 32'h0050);
      wait_conv(16'h0075, "mid-change second");
      model_cur = 75;
      scan_check(16, 75);

      // blank input suppresses anodes but not conversion
      blank = 1'b1;
      scan_check(16, 75);
      do_convert(321, 16'h0321);
      scan_check(8, 321);
      blank = 1'b0;
      scan_check(16, 321);

      // reset in the middle of a conversion (after 6 shifts)
      value = 12'd100;
      @(negedge clk);
      check("abort busy", 32'(busy), 32'h1);
      repeat (6) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("abort");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_conv(16'h0100, "post-abort v=100");
      model_cur = 100;
      scan_check(16, 100);

      // randomized values and blank against the arithmetic model
      for (int i = 0; i < 25; i++) begin
         v = int'($urandom_range(0, 4095));
         if (i == 5) v = model_cur;
         blank = 1'($urandom_range(0, 1));
         do_convert(v, to_bcd(v));
         scan_check(8, v);
      end
      blank = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
